// File: rtl/p5_ctrl_pkg.sv
// Shared types and encodings for the Simple RISC Machine control stage:
// FSM states, instruction classes, opcode fields, memory commands and
// writeback-source selects.
package p5_ctrl_pkg;

  // Opcode field values (IR[15:13])
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op field values (IR[12:11]) used to qualify the opcodes above
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // Memory command codes
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Writeback source selects
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPD_PC,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG,
    S_ADDR,
    S_LD_DA,
    S_MEM_RD,
    S_MEM_WB,
    S_GET_D,
    S_PASS_D,
    S_MEM_WR,
    S_HALT
  } state_t;

  // Instruction classes: each one maps to a distinct post-decode sequence.
  // ADD and AND share IC_ALU2; HALT and every undefined encoding map to IC_HALT.
  typedef enum logic [2:0] {
    IC_MOV_IMM,
    IC_MOV_REG,
    IC_MVN,
    IC_ALU2,
    IC_CMP,
    IC_LDR,
    IC_STR,
    IC_HALT
  } iclass_t;

  function automatic iclass_t classify(input logic [2:0] opcode, input logic [1:0] op);
    iclass_t c;
    c = IC_HALT;
    if (opcode == OPC_MOV && op == OP_MOV_IMM)      c = IC_MOV_IMM;
    else if (opcode == OPC_MOV && op == OP_MOV_REG) c = IC_MOV_REG;
    else if (opcode == OPC_ALU && op == OP_MVN)     c = IC_MVN;
    else if (opcode == OPC_ALU && op == OP_ADD)     c = IC_ALU2;
    else if (opcode == OPC_ALU && op == OP_AND)     c = IC_ALU2;
    else if (opcode == OPC_ALU && op == OP_CMP)     c = IC_CMP;
    else if (opcode == OPC_LDR && op == OP_MEM)     c = IC_LDR;
    else if (opcode == OPC_STR && op == OP_MEM)     c = IC_STR;
    return c;
  endfunction

endpackage

// File: rtl/p5_instr_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// its fields, sign-extends the immediates and classifies the instruction.
module p5_instr_decoder
  import p5_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output iclass_t     iclass
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  assign iclass = classify(opcode, op);

endmodule

// File: rtl/p5_controller.sv
// Control stage for the Simple RISC Machine datapath. Holds PC, IR and the
// data-address register and runs a Moore FSM that drives every datapath
// strobe/select and the memory command/address.
module p5_controller
  import p5_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       read_data,
  input  logic [15:0]       datapath_out,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        writenum,
  output logic [2:0]        readnum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [15:0]       sximm5,
  output logic [15:0]       sximm8,
  output logic [15:0]       pc_out,
  output logic              halted
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [15:0]       ir_reg;
  logic [ADDR_W-1:0] da_reg;

  // Internal controls for the local registers and the address mux
  logic addr_sel;
  logic load_ir;
  logic load_pc;
  logic load_da;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  iclass_t    iclass;

  p5_instr_decoder u_dec (
    .ir     (ir_reg),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  // Only the low ADDR_W bits of the effective address reach memory.
  generate
    if (ADDR_W < 16) begin : g_unused_dp
      logic unused_dp_hi;
      assign unused_dp_hi = ^datapath_out[15:ADDR_W];
    end
  endgenerate

  assign mem_addr = addr_sel ? pc_reg : da_reg;
  assign pc_out   = 16'(pc_reg);

  // State register; reset aborts any instruction in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_RST;
    else        state_reg <= state_next;
  end

  // PC, IR and data-address registers, each loaded by its own strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
      ir_reg <= '0;
      da_reg <= '0;
    end else begin
      if (load_pc) pc_reg <= pc_reg + ADDR_W'(1);
      if (load_ir) ir_reg <= read_data;
      if (load_da) da_reg <= datapath_out[ADDR_W-1:0];
    end
  end

  // Next-state and Moore outputs; every output is idle unless its state drives it.
  always_comb begin
    state_next = state_reg;
    addr_sel   = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    load_da    = 1'b0;
    mem_cmd    = MEM_NONE;
    writenum   = 3'd0;
    readnum    = 3'd0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    vsel       = VSEL_C;
    shift      = 2'b00;
    ALUop      = 2'b00;
    halted     = 1'b0;

    case (state_reg)
      S_RST: state_next = S_IF1;

      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        state_next = S_IF2;
      end

      // Read data for the IF1 address is valid now; capture it into IR.
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        load_ir    = 1'b1;
        state_next = S_UPD_PC;
      end

      S_UPD_PC: begin
        load_pc    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (iclass)
          IC_MOV_IMM:                   state_next = S_WR_IMM;
          IC_MOV_REG, IC_MVN:           state_next = S_GET_B;
          IC_ALU2, IC_CMP, IC_LDR, IC_STR: state_next = S_GET_A;
          default:                      state_next = S_HALT;
        endcase
      end

      S_WR_IMM: begin
        write      = 1'b1;
        writenum   = rn;
        vsel       = VSEL_IMM8;
        state_next = S_IF1;
      end

      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = (iclass == IC_LDR || iclass == IC_STR) ? S_ADDR : S_GET_B;
      end

      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_ALU;
      end

      // MOV/MVN ignore the A operand, so asel forces it to zero.
      S_ALU: begin
        shift = sh;
        asel  = (iclass == IC_MOV_REG || iclass == IC_MVN);
        ALUop = (opcode == OPC_ALU) ? op : 2'b00;
        if (iclass == IC_CMP) begin
          loads      = 1'b1;
          state_next = S_IF1;
        end else begin
          loadc      = 1'b1;
          state_next = S_WR_REG;
        end
      end

      S_WR_REG: begin
        write      = 1'b1;
        writenum   = rd;
        vsel       = VSEL_C;
        state_next = S_IF1;
      end

      // Effective address = Rn + sximm5; shift stays 00 as IR[4:3] is imm5 here.
      S_ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_LD_DA;
      end

      S_LD_DA: begin
        load_da    = 1'b1;
        state_next = (iclass == IC_LDR) ? S_MEM_RD : S_GET_D;
      end

      S_MEM_RD: begin
        mem_cmd    = MEM_READ;
        state_next = S_MEM_WB;
      end

      // Read is held so the synchronous RAM output stays valid for writeback.
      S_MEM_WB: begin
        mem_cmd    = MEM_READ;
        write      = 1'b1;
        writenum   = rd;
        vsel       = VSEL_MDATA;
        state_next = S_IF1;
      end

      S_GET_D: begin
        readnum    = rd;
        loadb      = 1'b1;
        state_next = S_PASS_D;
      end

      // Pass Rd through the ALU (0 + B) so it appears on datapath_out.
      S_PASS_D: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_MEM_WR;
      end

      S_MEM_WR: begin
        mem_cmd    = MEM_WRITE;
        state_next = S_IF1;
      end

      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end

      default: state_next = S_RST;
    endcase
  end

endmodule
